// File: rtl/agc_rupt_scheduler_if.sv
// Interrupt scheduler bus: request/inhibit inputs from the sequencer and
// the RUPT force, vector and acknowledge outputs back to it.
// The master side is the sequencer, the slave side is agc_rupt_scheduler.
interface agc_rupt_scheduler_if #(
  parameter int NSRC = 10
);
  logic [NSRC-1:0] RUPTREQ;
  logic            NISQ;
  logic            INHINT;
  logic            EXT;
  logic            OVNHRP;
  logic            RSM3;
  logic            RPTFRC;
  logic            IIP;
  logic [11:0]     RUPTADR;
  logic [NSRC-1:0] KRPT;
  logic [NSRC-1:0] PEND;
  logic            RPTLOCK;

  modport master (
    output RUPTREQ, NISQ, INHINT, EXT, OVNHRP, RSM3,
    input  RPTFRC, IIP, RUPTADR, KRPT, PEND, RPTLOCK
  );

  modport slave (
    input  RUPTREQ, NISQ, INHINT, EXT, OVNHRP, RSM3,
    output RPTFRC, IIP, RUPTADR, KRPT, PEND, RPTLOCK
  );
endinterface

// File: rtl/agc_rupt_scheduler.sv
// RUPT priority scheduler: latches interrupt requests, arms a forced RUPT
// sequence when nothing inhibits it, services the lowest pending index at
// the next instruction boundary and holds interrupt-in-progress until RESUME.
// Optional rupt-lock alarm is built only when RUPT_LOCK_EN is defined;
// otherwise RPTLOCK is tied low.
module agc_rupt_scheduler #(
  parameter int          NSRC       = 10,
  parameter logic [11:0] VEC_BASE   = 12'o4000,
  parameter logic [15:0] LOCK_LIMIT = 16'd4096
) (
  input  logic                 CLOCK,
  input  logic                 rst,
  input  logic                 GOJAM,
  agc_rupt_scheduler_if.slave  bus
);
  localparam int SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    INRUPT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [NSRC-1:0]  pend;
  logic [NSRC-1:0]  pend_next;
  logic [NSRC-1:0]  grant;
  logic [NSRC-1:0]  krpt;
  logic [11:0]      rupt_adr;
  logic [11:0]      rupt_adr_next;
  logic [SEL_W-1:0] sel;
  logic             elig;
  logic             restart;

  // GOJAM is a hardware restart and behaves exactly like rst.
  assign restart = rst | GOJAM;

  // A RUPT may only be armed outside an interrupt with nothing inhibiting it.
  assign elig = (pend != '0) & ~bus.INHINT & ~bus.EXT & ~bus.OVNHRP & (state != INRUPT);

  // Lowest set pending index wins; scanning downward leaves the lowest one last.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i]) sel = SEL_W'(i);
    end
  end

  // Next-state logic; a request landing on the bit being cleared keeps it set.
  always_comb begin
    state_next    = state;
    grant         = '0;
    rupt_adr_next = rupt_adr;
    unique case (state)
      IDLE: begin
        if (elig) state_next = ARMED;
      end
      ARMED: begin
        if (!elig) begin
          state_next = IDLE;
        end else if (bus.NISQ) begin
          state_next    = INRUPT;
          grant         = {{(NSRC-1){1'b0}}, 1'b1} << sel;
          rupt_adr_next = VEC_BASE + ((12'(sel) + 12'd1) << 2);
        end
      end
      INRUPT: begin
        if (bus.RSM3) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    pend_next = (pend & ~grant) | bus.RUPTREQ;
  end

  // State, pending latch, vector and one-cycle acknowledge registers.
  always_ff @(posedge CLOCK) begin
    if (restart) begin
      state    <= IDLE;
      pend     <= '0;
      krpt     <= '0;
      rupt_adr <= '0;
    end else begin
      state    <= state_next;
      pend     <= pend_next;
      krpt     <= grant;
      rupt_adr <= rupt_adr_next;
    end
  end

  assign bus.RPTFRC  = (state == ARMED);
  assign bus.IIP     = (state == INRUPT);
  assign bus.RUPTADR = rupt_adr;
  assign bus.KRPT    = krpt;
  assign bus.PEND    = pend;

`ifdef RUPT_LOCK_EN
  logic [15:0] lock_cnt;
  logic [15:0] lock_cnt_next;
  logic        rpt_lock;

  // Count instruction boundaries spent inside an interrupt, saturating at all-ones.
  always_comb begin
    lock_cnt_next = '0;
    if (state == INRUPT) begin
      lock_cnt_next = lock_cnt;
      if (bus.NISQ && (lock_cnt != 16'hFFFF)) lock_cnt_next = lock_cnt + 16'd1;
    end
  end

  // Alarm sets as the count reaches the limit and stays set until restart.
  always_ff @(posedge CLOCK) begin
    if (restart) begin
      lock_cnt <= '0;
      rpt_lock <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_next;
      rpt_lock <= rpt_lock | (lock_cnt_next >= LOCK_LIMIT);
    end
  end

  assign bus.RPTLOCK = rpt_lock;
`else
  logic [15:0] unused_lock_limit;
  assign unused_lock_limit = LOCK_LIMIT;
  assign bus.RPTLOCK = 1'b0;
`endif

endmodule

// File: tb/tb_agc_rupt_scheduler.sv
// Self-checking bench for agc_rupt_scheduler: directed scenarios followed by
// random traffic, all checked against a behavioural model of the RUPT rules.
// Define RUPT_LOCK_EN to also model the rupt-lock alarm (limit 8 here).
module tb_agc_rupt_scheduler;
  localparam int NSRC = 10;
  localparam int LIMIT = 8;

  logic clk;
  logic rst;
  logic gojam;

  int check_count = 0;
  int fail_count  = 0;

  // Behavioural expectations
  logic [NSRC-1:0] m_pend;
  logic            m_rptfrc;
  logic            m_iip;
  logic [11:0]     m_adr;
  logic [NSRC-1:0] m_krpt;
  logic            m_lock;
  int              m_nisq_in_rupt;

  agc_rupt_scheduler_if #(.NSRC(NSRC)) bus ();

  agc_rupt_scheduler #(
    .NSRC(NSRC),
    .VEC_BASE(12'o4000),
    .LOCK_LIMIT(16'(LIMIT))
  ) dut (
    .CLOCK(clk),
    .rst(rst),
    .GOJAM(gojam),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lowest_pending(input logic [NSRC-1:0] p);
    for (int i = 0; i < NSRC; i++) begin
      if (p[i]) return i;
    end
    return -1;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit ok_to_rupt;
    int k;
    logic [NSRC-1:0] served;
    served = '0;
    if (rst || gojam) begin
      m_pend = '0; m_rptfrc = 0; m_iip = 0; m_adr = '0; m_krpt = '0;
      m_lock = 0; m_nisq_in_rupt = 0;
    end else begin
      ok_to_rupt = (m_pend != 0) && !bus.INHINT && !bus.EXT && !bus.OVNHRP && !m_iip;
`ifdef RUPT_LOCK_EN
      if (!m_iip) m_nisq_in_rupt = 0;
      else if (bus.NISQ && m_nisq_in_rupt < 65535) m_nisq_in_rupt++;
      if (m_nisq_in_rupt >= LIMIT) m_lock = 1;
`endif
      m_krpt = '0;
      if (m_iip) begin
        if (bus.RSM3) m_iip = 0;
      end else if (m_rptfrc) begin
        if (!ok_to_rupt) begin
          m_rptfrc = 0;
        end else if (bus.NISQ) begin
          k = lowest_pending(m_pend);
          served[k] = 1'b1;
          m_krpt = served;
          m_adr = 12'(2048 + 4 * (k + 1));
          m_iip = 1;
          m_rptfrc = 0;
        end
      end else if (ok_to_rupt) begin
        m_rptfrc = 1;
      end
      m_pend = (m_pend & ~served) | bus.RUPTREQ;
    end
  endtask

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_output();
    check_value("PEND",    32'(bus.PEND),    32'(m_pend));
    check_value("RPTFRC",  32'(bus.RPTFRC),  32'(m_rptfrc));
    check_value("IIP",     32'(bus.IIP),     32'(m_iip));
    check_value("RUPTADR", 32'(bus.RUPTADR), 32'(m_adr));
    check_value("KRPT",    32'(bus.KRPT),    32'(m_krpt));
    check_value("RPTLOCK", 32'(bus.RPTLOCK), 32'(m_lock));
  endtask

  // Drive one cycle of pulses, clock it, update the model and compare.
  task automatic apply_stimulus(input logic [NSRC-1:0] req, input logic nisq, input logic rsm3);
    bus.RUPTREQ = req;
    bus.NISQ    = nisq;
    bus.RSM3    = rsm3;
    @(posedge clk);
    model_step();
    #1;
    bus.RUPTREQ = '0;
    bus.NISQ    = 1'b0;
    bus.RSM3    = 1'b0;
    rst         = 1'b0;
    gojam       = 1'b0;
    check_output();
  endtask

  initial begin
    bus.RUPTREQ = '0; bus.NISQ = 0; bus.INHINT = 0; bus.EXT = 0;
    bus.OVNHRP = 0; bus.RSM3 = 0;
    m_pend = '0; m_rptfrc = 0; m_iip = 0; m_adr = '0; m_krpt = '0;
    m_lock = 0; m_nisq_in_rupt = 0;
    gojam = 0;
    rst = 1;
    @(negedge clk);
    $display("[TB] reset");
    apply_stimulus('0, 0, 0);

    $display("[TB] single T3RUPT request");
    apply_stimulus(10'b0000000100, 0, 0);
    check_value("t3_pend_plus1", 32'(bus.PEND), 32'h004);
    apply_stimulus('0, 0, 0);
    check_value("t3_rptfrc_plus2", 32'(bus.RPTFRC), 32'd1);
    for (int i = 0; i < 3; i++) apply_stimulus('0, 0, 0);
    apply_stimulus('0, 1, 0);
    check_value("t3_vector", 32'(bus.RUPTADR), 32'(12'o4014));
    check_value("t3_krpt", 32'(bus.KRPT), 32'h004);
    apply_stimulus('0, 0, 0);
    apply_stimulus('0, 0, 1);

    $display("[TB] simultaneous requests 1 and 6");
    apply_stimulus(10'b0001000010, 0, 0);
    apply_stimulus('0, 0, 0);
    apply_stimulus('0, 1, 0);
    check_value("dual_first_vector", 32'(bus.RUPTADR), 32'(12'o4010));
    check_value("dual_pend_left", 32'(bus.PEND), 32'h040);
    apply_stimulus('0, 0, 1);
    apply_stimulus('0, 0, 0);
    apply_stimulus('0, 1, 0);
    check_value("dual_second_vector", 32'(bus.RUPTADR), 32'(12'o4034));
    apply_stimulus('0, 0, 1);

    $display("[TB] inhibits while armed");
    for (int which = 0; which < 3; which++) begin
      apply_stimulus(10'b0000000001, 0, 0);
      apply_stimulus('0, 0, 0);
      if (which == 0) bus.INHINT = 1; else if (which == 1) bus.EXT = 1; else bus.OVNHRP = 1;
      apply_stimulus('0, 0, 0);
      apply_stimulus('0, 1, 0);
      bus.INHINT = 0; bus.EXT = 0; bus.OVNHRP = 0;
      apply_stimulus('0, 0, 0);
      apply_stimulus('0, 1, 0);
      apply_stimulus('0, 0, 1);
    end

    $display("[TB] request during interrupt");
    apply_stimulus(10'b0000001000, 0, 0);
    apply_stimulus('0, 0, 0);
    apply_stimulus('0, 1, 0);
    apply_stimulus(10'b0000000001, 1, 0);
    check_value("inrupt_pend0", 32'(bus.PEND), 32'h001);
    apply_stimulus('0, 0, 1);
    apply_stimulus('0, 0, 0);
    apply_stimulus('0, 1, 0);
    check_value("inrupt_then_t6_vector", 32'(bus.RUPTADR), 32'(12'o4004));

    $display("[TB] GOJAM mid-interrupt");
    apply_stimulus(10'b1000000001, 0, 0);
    gojam = 1;
    apply_stimulus('0, 0, 0);
    check_value("gojam_pend", 32'(bus.PEND), 32'h000);
    apply_stimulus('0, 0, 1);

    $display("[TB] long interrupt for lock alarm");
    apply_stimulus(10'b0100000000, 0, 0);
    apply_stimulus('0, 0, 0);
    apply_stimulus('0, 1, 0);
    for (int i = 0; i < LIMIT; i++) apply_stimulus('0, 1, 0);
    apply_stimulus('0, 0, 1);
    apply_stimulus('0, 0, 0);
    rst = 1;
    apply_stimulus('0, 0, 0);

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      logic [NSRC-1:0] req;
      req = ($urandom_range(0, 5) == 0) ? NSRC'($urandom) : '0;
      if ($urandom_range(0, 9) == 0) bus.INHINT = ~bus.INHINT;
      if ($urandom_range(0, 14) == 0) bus.EXT = ~bus.EXT;
      if ($urandom_range(0, 14) == 0) bus.OVNHRP = ~bus.OVNHRP;
      if ($urandom_range(0, 199) == 0) gojam = 1;
      if ($urandom_range(0, 299) == 0) rst = 1;
      apply_stimulus(req, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 11) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end
endmodule

// File: doc/agc_rupt_scheduler.md
Name: agc_rupt_scheduler

Overview:
Interrupt (RUPT) priority scheduler for the sequence-register/instruction-decode logic. Latches interrupt request pulses from up to NSRC sources and checks the inhibit conditions (INHINT, EXT, OVNHRP, IIP). At an instruction boundary (NISQ) it forces a RUPT sequence (RPTFRC), supplies the vector address and acknowledges the serviced source. It then holds interrupt-in-progress until RESUME (RSM3).

Parameters:
NSRC, 10, number of interrupt sources; index 0 is highest priority (T6RUPT, T5RUPT, T3RUPT, T4RUPT, KEYRUPT1, KEYRUPT2, UPRUPT, DOWNRUPT, RADARUPT, HANDRUPT)
VEC_BASE, 12'o4000, vector base; source i vectors to VEC_BASE + 4*(i+1)
LOCK_LIMIT, 16'd4096, NISQ count limit used only by the optional feature

Ports:
CLOCK  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous reset, active-high
GOJAM  in  1  hardware restart; same effect as rst, synchronous
RUPTREQ  in  NSRC  request pulses, one bit per source
NISQ  in  1  next-instruction boundary strobe, one cycle
INHINT  in  1  interrupts inhibited by software
EXT  in  1  extend pending; RUPT not allowed between EXTEND and its instruction
OVNHRP  in  1  overflow-in-accumulator inhibit
RSM3  in  1  RESUME executed; ends the interrupt
RPTFRC  out  1  force RUPT at next NISQ (registered level)
IIP  out  1  interrupt in progress
RUPTADR  out  12  vector address of the serviced source, held while IIP
KRPT  out  NSRC  one-hot acknowledge pulse, one cycle
PEND  out  NSRC  pending request bits
RPTLOCK  out  1  rupt-lock alarm (tied 0 unless RUPT_LOCK_EN)

Behaviour:
- Reset (rst or GOJAM): PEND=0, state IDLE, RPTFRC=0, IIP=0, RUPTADR=0, KRPT=0, RPTLOCK=0. Reset overrides all other inputs in the same cycle, including mid-interrupt.
- Pending latch: a RUPTREQ[i] pulse at cycle t sets PEND[i] at t+1. PEND[i] stays set until serviced. A repeat request on an already-pending source is absorbed (no count).
- If a request and a clear for the same bit land in the same cycle, the request wins: the bit stays set, and the source is serviced again later.
- elig = (PEND!=0) & !INHINT & !EXT & !OVNHRP & !IIP.
- FSM states: IDLE, ARMED, INRUPT.
  - IDLE: if elig, go to ARMED and RPTFRC=1 from the next cycle.
  - ARMED: RPTFRC=1.
    - If !elig (e.g. INHINT rises), return to IDLE; RPTFRC=0 next cycle.
    - Otherwise, on NISQ: pick the lowest set index k of PEND; clear PEND[k]; pulse KRPT[k] for one cycle; RUPTADR = VEC_BASE + 4*(k+1); IIP=1; RPTFRC=0. All of these take effect in the cycle after NISQ; go to INRUPT.
    - Priority is sampled in the NISQ cycle, so a higher-priority request that arrives in that same cycle is not considered.
  - INRUPT: IIP=1; new requests accumulate in PEND. On RSM3, go to IDLE with IIP=0 next cycle, RUPTADR holds its last value. RSM3 in IDLE or ARMED is ignored.
- NISQ outside ARMED has no effect on the FSM.
- Minimum latency from request to RPTFRC: 2 cycles (latch, then arm).

Optional Feature:
RUPT_LOCK_EN:
- When defined: a 16-bit counter increments on each NISQ while IIP=1 and clears when IIP=0. When the count reaches LOCK_LIMIT, RPTLOCK sets; it is sticky until rst or GOJAM. The counter saturates and does not wrap.
- When undefined: no counter is built, and RPTLOCK is constant 0.

Test Plan:
- Reset then RUPTREQ=10'b0000000100 (T3RUPT), INHINT=EXT=OVNHRP=0, NISQ 5 cycles later -> PEND[2] at +1, RPTFRC at +2, then after NISQ: KRPT=10'b0000000100 for 1 cycle, RUPTADR=12'o4014, IIP=1, PEND=0.
- RUPTREQ bits 1 and 6 in the same cycle, then NISQ -> service index 1 (RUPTADR=12'o4010) with PEND[6] still 1; then RSM3 -> IIP=0, re-arm, next NISQ services 6 (RUPTADR=12'o4034).
- Pending T6RUPT in ARMED, INHINT raised before NISQ -> RPTFRC drops next cycle, NISQ ignored. INHINT lowered -> re-arm. Repeat with EXT and with OVNHRP.
- While IIP=1, pulse RUPTREQ[0] and NISQ -> no KRPT, no RPTFRC, PEND[0]=1. RSM3 -> servicing of 0 follows the normal sequence.
- GOJAM asserted in INRUPT with PEND=10'b1000000001 -> next cycle everything reads its reset value. Assert RSM3 in IDLE -> no change.
- With RUPT_LOCK_EN, LOCK_LIMIT=8: enter interrupt, apply 8 NISQ with no RSM3 -> RPTLOCK=1 after the 8th NISQ, stays 1 after RSM3, clears only on rst. Without the macro, RPTLOCK stays 0.
